risc8_sequencer: RTL and testbench
==================================

Name: risc8_sequencer

Overview:
- Multi-cycle control sequencer for the RISC-8 core; sits between the instruction decoder (5-bit instruction class) and the PC/SP/data-memory datapath.
- Single-cycle classes retire in one cycle.
- Sequences the multi-cycle classes: two-word fetch, data/program memory access, stack push/pop, skips and taken control flow.
- Drives PC increment/load, SP update, memory strobes and a stall that holds the decoder's current opcode.

Parameters:
PC_W, 16, program counter width; sets the number of stack bytes per CALL/RET (2 when PC_W>8, else 1).

Ports:
clk  in  1  core clock
reset  in  1  synchronous, active-high reset
instr_valid  in  1  decoder class is valid this cycle
instr  in  5  decoded instruction class (codes below)
cond_true  in  1  skip/branch condition is met (CPSE equal, SBRC/SBRS/SBIC/SBIS bit test, BRBC/BRBS flag test)
next_2word  in  1  word after the current one is a two-word opcode (LDS/JMP/CALL)
mem_ready  in  1  data memory completes the access this cycle
stall  out  1  hold the opcode register; decoder output is reused next cycle
pc_inc  out  1  PC <= PC+1
pc_load  out  1  PC <= source selected by pc_src
pc_src  out  2  0=PC+1+offset, 1=operand word, 2=Z, 3=stack bytes
sp_dec  out  1  push one byte, then SP-1
sp_inc  out  1  SP+1, then pop one byte
stack_hi  out  1  current stack byte is the PC high byte
mem_re  out  1  data memory read strobe
mem_we  out  1  data memory write strobe
pm_re  out  1  program memory data read (LPM)
flush  out  1  discard the fetched word (bubble)

Behaviour:
- Class codes: 0x00-0x09 single-cycle; 0x0a LDS; 0x0b/0x0c LD; 0x0d LPM; 0x0e POP; 0x0f PUSH; 0x10 RET; 0x11/0x12/0x19 skip; 0x13 branch; 0x14 JMP; 0x15 CALL; 0x16 IJMP; 0x17 RJMP; 0x18 RCALL.
- States: EXEC, OPERAND, MEM, LPM, PUSH, POP, SKIP, FLUSH.
- State encoding is implementation choice.
- Outputs are combinational from the state register plus the inputs.
- Reset forces EXEC, with the internal byte counter cleared. With instr_valid=0 every output is 0.
- Reset mid-sequence aborts immediately; no strobe is asserted in the reset cycle.
- EXEC, instr_valid=0: all outputs 0; state holds.
- EXEC, classes 0x00-0x09: pc_inc=1, stay in EXEC. Latency 1.
- LDS:
  - EXEC: pc_inc, stall -> OPERAND.
  - OPERAND: pc_inc, mem_re, stall -> MEM.
  - MEM: the strobe is held until mem_ready=1, then -> EXEC.
  - Total 3 cycles at zero wait.
- LD/LD+q: EXEC asserts mem_re and stall -> MEM; MEM asserts pc_inc on completion. 2 cycles.
- LPM: EXEC asserts pm_re and stall -> LPM; LPM asserts pc_inc and flush -> EXEC. 2 cycles.
- PUSH: EXEC asserts sp_dec, mem_we, pc_inc. PUSH/POP states are used only by CALL/RCALL/RET.
- POP: EXEC asserts sp_inc, mem_re, stall -> MEM. 2 cycles.
- CALL:
  - EXEC: pc_inc, stall -> OPERAND.
  - OPERAND: pc_inc, stall -> PUSH.
  - PUSH: lo byte then hi byte (stack_hi=0, then 1), each with sp_dec and mem_we.
  - After the last byte: pc_load with pc_src=1 -> FLUSH.
- RCALL: same as CALL, but EXEC goes directly to PUSH (pc_inc) and loads with pc_src=0.
- RET: POP hi byte then lo byte, each with sp_inc and mem_re. Then pc_load with pc_src=3 -> FLUSH.
- JMP: EXEC -> OPERAND; OPERAND asserts pc_load with pc_src=1 -> FLUSH.
- RJMP: pc_load with pc_src=0. IJMP: pc_load with pc_src=2. Both go to FLUSH.
- Branch: cond_true=1 acts as RJMP; cond_true=0 acts as single-cycle.
- FLUSH: flush=1, pc_inc=1 -> EXEC. Every taken transfer costs exactly one bubble.
- Skip classes:
  - cond_true=0: single-cycle.
  - cond_true=1: pc_inc, flush -> SKIP.
  - SKIP: pc_inc; if next_2word was sampled as 1 in EXEC, one more pc_inc cycle before EXEC.
- With a single-byte stack (PC_W<=8), PUSH/POP perform one byte only (stack_hi=0).
- Simultaneous pc_inc and pc_load never occur; pc_load has priority by construction.
- sp_inc and sp_dec are never both 1.
- instr_valid is ignored outside EXEC.

Optional Feature:
- Macro: RISC8_SEQ_WAIT_EN.
- Defined: MEM holds its strobe and stall until mem_ready=1. This applies to each stack byte too, so a byte advances only on mem_ready.
- Undefined: mem_ready is ignored; every memory access completes in one cycle. Cycle counts equal the zero-wait numbers above.

Test Plan:
- reset=1 during CALL PUSH -> next cycle all outputs 0, state EXEC, sp_dec=0.
- ADD (0x00) stream, instr_valid=1 -> pc_inc=1 every cycle, stall=0.
- CALL (0x15), PC_W=16, zero wait -> 6 cycles:
  - pc_inc, pc_inc
  - sp_dec+mem_we stack_hi=0, sp_dec+mem_we stack_hi=1
  - pc_load pc_src=1
  - flush
- RET (0x10) with RISC8_SEQ_WAIT_EN, mem_ready low 2 cycles on the first byte -> mem_re held 3 cycles, then second byte, then pc_load pc_src=3, then flush.
- SBRC (0x12), cond_true=1, next_2word=1 -> pc_inc for 3 consecutive cycles, flush in the first.
- BRBS (0x13): cond_true=0 -> single pc_inc; cond_true=1 -> pc_load pc_src=0, then flush.

Source files
------------

// File: rtl/risc8_sequencer.sv
// risc8_sequencer: multi-cycle control sequencer for the RISC-8 core.
// Turns the decoder's instruction class into PC, SP, memory and stall/flush
// controls. The class is latched on entry to a multi-cycle sequence, so the
// decoder inputs only matter in EXEC.
// Optional build macro RISC8_SEQ_WAIT_EN: memory accesses (MEM state and each
// stack byte) wait for mem_ready; without it mem_ready is ignored and every
// access completes in one cycle.
module risc8_sequencer #(
    parameter int PC_W = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       instr_valid,
    input  logic [4:0] instr,
    input  logic       cond_true,
    input  logic       next_2word,
    input  logic       mem_ready,
    output logic       stall,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [1:0] pc_src,
    output logic       sp_dec,
    output logic       sp_inc,
    output logic       stack_hi,
    output logic       mem_re,
    output logic       mem_we,
    output logic       pm_re,
    output logic       flush
);

    // Return addresses wider than a byte take two stack bytes.
    localparam logic [1:0] NBYTES = (PC_W > 8) ? 2'd2 : 2'd1;

    localparam logic [4:0] C_LDS   = 5'h0a;
    localparam logic [4:0] C_LD0   = 5'h0b;
    localparam logic [4:0] C_LD1   = 5'h0c;
    localparam logic [4:0] C_LPM   = 5'h0d;
    localparam logic [4:0] C_POP   = 5'h0e;
    localparam logic [4:0] C_PUSH  = 5'h0f;
    localparam logic [4:0] C_RET   = 5'h10;
    localparam logic [4:0] C_SKIP0 = 5'h11;
    localparam logic [4:0] C_SKIP1 = 5'h12;
    localparam logic [4:0] C_BR    = 5'h13;
    localparam logic [4:0] C_JMP   = 5'h14;
    localparam logic [4:0] C_CALL  = 5'h15;
    localparam logic [4:0] C_IJMP  = 5'h16;
    localparam logic [4:0] C_RJMP  = 5'h17;
    localparam logic [4:0] C_RCALL = 5'h18;
    localparam logic [4:0] C_SKIP2 = 5'h19;

    typedef enum logic [2:0] {
        S_EXEC,
        S_OPERAND,
        S_MEM,
        S_LPM,
        S_PUSH,
        S_POP,
        S_SKIP,
        S_FLUSH
    } state_t;

    state_t     state, state_nxt;
    logic [4:0] cls, cls_nxt;     // class of the sequence in progress
    logic [1:0] cnt, cnt_nxt;     // stack byte / skip word counter
    logic       two, two_nxt;     // skipped instruction is two words
    logic       done;             // current memory access completes this cycle

`ifdef RISC8_SEQ_WAIT_EN
    assign done = mem_ready;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = mem_ready;
    assign done = 1'b1;
`endif

    // Sequencer state register; reset aborts any sequence in progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_EXEC;
            cls   <= 5'd0;
            cnt   <= 2'd0;
            two   <= 1'b0;
        end else begin
            state <= state_nxt;
            cls   <= cls_nxt;
            cnt   <= cnt_nxt;
            two   <= two_nxt;
        end
    end

    // Next state and combinational control outputs; all quiet during reset.
    always_comb begin
        state_nxt = state;
        cls_nxt   = cls;
        cnt_nxt   = cnt;
        two_nxt   = two;
        stall     = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        pc_src    = 2'd0;
        sp_dec    = 1'b0;
        sp_inc    = 1'b0;
        stack_hi  = 1'b0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        pm_re     = 1'b0;
        flush     = 1'b0;
        if (!reset) begin
            case (state)
                S_EXEC: begin
                    if (instr_valid) begin
                        cls_nxt = instr;
                        cnt_nxt = 2'd0;
                        two_nxt = 1'b0;
                        case (instr)
                            C_LDS, C_CALL, C_JMP: begin
                                pc_inc    = 1'b1;
                                stall     = 1'b1;
                                state_nxt = S_OPERAND;
                            end
                            C_LD0, C_LD1: begin
                                mem_re    = 1'b1;
                                stall     = 1'b1;
                                state_nxt = S_MEM;
                            end
                            C_LPM: begin
                                pm_re     = 1'b1;
                                stall     = 1'b1;
                                state_nxt = S_LPM;
                            end
                            C_POP: begin
                                sp_inc    = 1'b1;
                                mem_re    = 1'b1;
                                stall     = 1'b1;
                                state_nxt = S_MEM;
                            end
                            C_PUSH: begin
                                sp_dec = 1'b1;
                                mem_we = 1'b1;
                                pc_inc = 1'b1;
                            end
                            C_RET: begin
                                stall     = 1'b1;
                                state_nxt = S_POP;
                            end
                            C_SKIP0, C_SKIP1, C_SKIP2: begin
                                pc_inc = 1'b1;
                                if (cond_true) begin
                                    flush     = 1'b1;
                                    two_nxt   = next_2word;
                                    state_nxt = S_SKIP;
                                end
                            end
                            C_BR: begin
                                if (cond_true) begin
                                    pc_load   = 1'b1;
                                    pc_src    = 2'd0;
                                    state_nxt = S_FLUSH;
                                end else begin
                                    pc_inc = 1'b1;
                                end
                            end
                            C_IJMP: begin
                                pc_load   = 1'b1;
                                pc_src    = 2'd2;
                                state_nxt = S_FLUSH;
                            end
                            C_RJMP: begin
                                pc_load   = 1'b1;
                                pc_src    = 2'd0;
                                state_nxt = S_FLUSH;
                            end
                            C_RCALL: begin
                                pc_inc    = 1'b1;
                                stall     = 1'b1;
                                state_nxt = S_PUSH;
                            end
                            default: pc_inc = 1'b1;
                        endcase
                    end
                end
                S_OPERAND: begin
                    case (cls)
                        C_LDS: begin
                            pc_inc    = 1'b1;
                            mem_re    = 1'b1;
                            stall     = 1'b1;
                            state_nxt = S_MEM;
                        end
                        C_CALL: begin
                            pc_inc    = 1'b1;
                            stall     = 1'b1;
                            state_nxt = S_PUSH;
                        end
                        C_JMP: begin
                            pc_load   = 1'b1;
                            pc_src    = 2'd1;
                            state_nxt = S_FLUSH;
                        end
                        default: state_nxt = S_EXEC;
                    endcase
                end
                S_MEM: begin
                    // Strobe held until the access completes; LDS already
                    // advanced the PC past both of its words.
                    mem_re = 1'b1;
                    if (done) begin
                        pc_inc    = (cls != C_LDS);
                        state_nxt = S_EXEC;
                    end else begin
                        stall = 1'b1;
                    end
                end
                S_LPM: begin
                    pc_inc    = 1'b1;
                    flush     = 1'b1;
                    state_nxt = S_EXEC;
                end
                S_PUSH: begin
                    // Low byte first; SP only moves when the byte completes.
                    if (cnt < NBYTES) begin
                        mem_we   = 1'b1;
                        stall    = 1'b1;
                        stack_hi = (cnt == 2'd1);
                        if (done) begin
                            sp_dec  = 1'b1;
                            cnt_nxt = cnt + 2'd1;
                        end
                    end else begin
                        pc_load   = 1'b1;
                        pc_src    = (cls == C_RCALL) ? 2'd0 : 2'd1;
                        cnt_nxt   = 2'd0;
                        state_nxt = S_FLUSH;
                    end
                end
                S_POP: begin
                    // High byte first when the return address spans two bytes.
                    if (cnt < NBYTES) begin
                        mem_re   = 1'b1;
                        stall    = 1'b1;
                        stack_hi = (NBYTES == 2'd2) && (cnt == 2'd0);
                        if (done) begin
                            sp_inc  = 1'b1;
                            cnt_nxt = cnt + 2'd1;
                        end
                    end else begin
                        pc_load   = 1'b1;
                        pc_src    = 2'd3;
                        cnt_nxt   = 2'd0;
                        state_nxt = S_FLUSH;
                    end
                end
                S_SKIP: begin
                    pc_inc = 1'b1;
                    if (two && (cnt == 2'd0)) begin
                        cnt_nxt = 2'd1;
                    end else begin
                        cnt_nxt   = 2'd0;
                        two_nxt   = 1'b0;
                        state_nxt = S_EXEC;
                    end
                end
                S_FLUSH: begin
                    flush     = 1'b1;
                    pc_inc    = 1'b1;
                    state_nxt = S_EXEC;
                end
                default: state_nxt = S_EXEC;
            endcase
        end
    end

endmodule

// File: tb/tb_risc8_sequencer.sv
// Testbench for risc8_sequencer: directed sequences followed by random
// instruction streams, each checked cycle by cycle against an expected
// output list built from the per-class timing rules.
// Honours RISC8_SEQ_WAIT_EN when compiled with the same macro as the RTL.
module tb_risc8_sequencer;

    localparam int PC_W = 16;

    typedef logic [11:0] ov_t;
    localparam ov_t O_STALL = 12'h800;
    localparam ov_t O_INC   = 12'h400;
    localparam ov_t O_LOAD  = 12'h200;
    localparam ov_t O_SPD   = 12'h040;
    localparam ov_t O_SPI   = 12'h020;
    localparam ov_t O_HI    = 12'h010;
    localparam ov_t O_RE    = 12'h008;
    localparam ov_t O_WE    = 12'h004;
    localparam ov_t O_PM    = 12'h002;
    localparam ov_t O_FLUSH = 12'h001;

    logic       clk = 1'b0;
    logic       reset;
    logic       instr_valid;
    logic [4:0] instr;
    logic       cond_true;
    logic       next_2word;
    logic       mem_ready;
    logic       stall, pc_inc, pc_load, sp_dec, sp_inc, stack_hi;
    logic       mem_re, mem_we, pm_re, flush;
    logic [1:0] pc_src;
    ov_t        obs;

    int tests = 0;
    int fails = 0;
    int force_wait = -1;
    ov_t  exp_q[$];
    logic rdy_q[$];

    risc8_sequencer #(.PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr(instr),
        .cond_true(cond_true), .next_2word(next_2word), .mem_ready(mem_ready),
        .stall(stall), .pc_inc(pc_inc), .pc_load(pc_load), .pc_src(pc_src),
        .sp_dec(sp_dec), .sp_inc(sp_inc), .stack_hi(stack_hi),
        .mem_re(mem_re), .mem_we(mem_we), .pm_re(pm_re), .flush(flush)
    );

    always #5 clk = ~clk;

    assign obs = {stall, pc_inc, pc_load, pc_src, sp_dec, sp_inc, stack_hi,
                  mem_re, mem_we, pm_re, flush};

    function automatic ov_t ld(input int src);
        return O_LOAD | (ov_t'(src) << 7);
    endfunction

    // Check the current cycle's outputs away from the edge, then advance.
    task automatic cyc(input string tag, input ov_t e);
        @(negedge clk);
        tests++;
        assert (obs === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic add(input ov_t v);
        exp_q.push_back(v);
        rdy_q.push_back(1'($urandom));
    endtask

    // One memory access: optional wait cycles hold the strobe and stall
    // with no PC/SP progress, then the completing cycle.
    task automatic add_acc(input ov_t fv);
`ifdef RISC8_SEQ_WAIT_EN
        int k;
        k = (force_wait >= 0) ? force_wait : int'($urandom_range(0, 2));
        force_wait = -1;
        repeat (k) begin
            exp_q.push_back((fv & ~(O_INC | O_SPD | O_SPI)) | O_STALL);
            rdy_q.push_back(1'b0);
        end
        exp_q.push_back(fv);
        rdy_q.push_back(1'b1);
`else
        force_wait = -1;
        exp_q.push_back(fv);
        rdy_q.push_back(1'($urandom));
`endif
    endtask

    // Expected per-cycle outputs for one instruction class.
    task automatic build(input logic [4:0] c, input logic cnd, input logic n2w);
        int nb;
        nb = (PC_W > 8) ? 2 : 1;
        exp_q.delete();
        rdy_q.delete();
        case (c)
            5'h0a: begin add(O_INC | O_STALL); add(O_INC | O_RE | O_STALL); add_acc(O_RE); end
            5'h0b, 5'h0c: begin add(O_RE | O_STALL); add_acc(O_RE | O_INC); end
            5'h0d: begin add(O_PM | O_STALL); add(O_INC | O_FLUSH); end
            5'h0e: begin add(O_SPI | O_RE | O_STALL); add_acc(O_RE | O_INC); end
            5'h0f: add(O_SPD | O_WE | O_INC);
            5'h10: begin
                add(O_STALL);
                for (int b = 0; b < nb; b++)
                    add_acc(O_RE | O_STALL | O_SPI | ((nb == 2 && b == 0) ? O_HI : 12'h000));
                add(ld(3));
                add(O_FLUSH | O_INC);
            end
            5'h11, 5'h12, 5'h19: begin
                if (cnd) begin
                    add(O_INC | O_FLUSH);
                    add(O_INC);
                    if (n2w) add(O_INC);
                end else add(O_INC);
            end
            5'h13: begin
                if (cnd) begin add(ld(0)); add(O_FLUSH | O_INC); end
                else add(O_INC);
            end
            5'h14: begin add(O_INC | O_STALL); add(ld(1)); add(O_FLUSH | O_INC); end
            5'h15, 5'h18: begin
                add(O_INC | O_STALL);
                if (c == 5'h15) add(O_INC | O_STALL);
                for (int b = 0; b < nb; b++)
                    add_acc(O_WE | O_STALL | O_SPD | ((b == 1) ? O_HI : 12'h000));
                add(ld((c == 5'h15) ? 1 : 0));
                add(O_FLUSH | O_INC);
            end
            5'h16: begin add(ld(2)); add(O_FLUSH | O_INC); end
            5'h17: begin add(ld(0)); add(O_FLUSH | O_INC); end
            default: add(O_INC);
        endcase
    endtask

    // Issue one instruction in EXEC, then random noise on the decoder inputs
    // for the rest of the sequence (they must be ignored).
    task automatic run(input string tag, input logic [4:0] c, input logic cnd, input logic n2w);
        build(c, cnd, n2w);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 0) begin
                instr_valid = 1'b1;
                instr       = c;
                cond_true   = cnd;
                next_2word  = n2w;
            end else begin
                instr_valid = 1'($urandom);
                instr       = 5'($urandom);
                cond_true   = 1'($urandom);
                next_2word  = 1'($urandom);
            end
            mem_ready = rdy_q[i];
            cyc(tag, exp_q[i]);
        end
    endtask

    task automatic idle();
        instr_valid = 1'b0;
        instr       = 5'($urandom);
        cond_true   = 1'($urandom);
        next_2word  = 1'($urandom);
        mem_ready   = 1'($urandom);
        cyc("idle", 12'h000);
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 5'h15;
        cond_true   = 1'b0;
        next_2word  = 1'b0;
        mem_ready   = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_quiet", 12'h000);
        cyc("reset_quiet2", 12'h000);
        reset = 1'b0;
        idle();

        // ADD stream
        for (int i = 0; i < 4; i++) run("add_stream", 5'h00, 1'b0, 1'b0);
        run("call", 5'h15, 1'b0, 1'b0);
        force_wait = 2;
        run("ret_wait", 5'h10, 1'b0, 1'b0);
        run("sbrc_2word", 5'h12, 1'b1, 1'b1);
        run("sbrc_1word", 5'h12, 1'b1, 1'b0);
        run("sbrc_false", 5'h12, 1'b0, 1'b1);
        run("brbs_false", 5'h13, 1'b0, 1'b0);
        run("brbs_true", 5'h13, 1'b1, 1'b0);
        run("lds", 5'h0a, 1'b0, 1'b0);
        run("rcall", 5'h18, 1'b0, 1'b0);
        run("jmp", 5'h14, 1'b0, 1'b0);

        // Reset in the middle of CALL's first stack byte.
        instr_valid = 1'b1;
        instr       = 5'h15;
        mem_ready   = 1'b1;
        cyc("abort_exec", O_INC | O_STALL);
        cyc("abort_operand", O_INC | O_STALL);
        reset = 1'b1;
        cyc("abort_reset_cycle", 12'h000);
        reset = 1'b0;
        idle();
        run("after_abort", 5'h00, 1'b0, 1'b0);

        // Random instruction stream
        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 4) == 0) idle();
            run("random", 5'($urandom_range(0, 25)), 1'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
